// File: rtl/seq_adder_pkg.sv
// Shared definitions for the sequential chunked adder.
//   state_t        : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   calc_nchunk()  : number of RUN cycles for a given operand/chunk width
//   calc_cnt_w()   : width of the chunk counter (at least 1 bit)
package seq_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk operation still needs a 1-bit counter so the
    // port/select logic never collapses to zero width.
    function automatic int calc_cnt_w(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder slice with carry in/out.
// Ports:
//   a, b : CHUNK-bit addends
//   ci   : carry in
//   s    : CHUNK-bit sum
//   co   : carry out (MSB of the CHUNK+1 bit sum)
module chunk_adder #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract unit: {Cout,S} = X + Y + Cin, or X - Y - borrow,
// computed CHUNK bits per clock, least significant chunk first.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : request an operation (accepted only in IDLE)
//   sub             : 0 = add, 1 = subtract (sampled with start)
//   X, Y, Cin       : operands and carry/borrow in (sampled with start)
//   busy            : high during the NCHUNK RUN cycles
//   done            : one-cycle pulse, result valid
//   S, Cout, V      : registered result, carry out (sub: 1 = no borrow),
//                     two's-complement overflow
import seq_adder_pkg::*;

module seq_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int KW     = calc_cnt_w(NCHUNK);
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] xa;
    logic [WIDTH-1:0] ya;
    logic             c;
    logic [KW-1:0]    k;

    logic [CHUNK-1:0] a_sel;
    logic [CHUNK-1:0] b_sel;
    logic [CHUNK-1:0] sum;
    logic             co;
    logic [WIDTH-1:0] s_upd;
    logic             last;

    assign last = (k == K_LAST);

    // Operand chunk selection by the chunk counter.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (k == KW'(i)) begin
                a_sel = xa[i*CHUNK +: CHUNK];
                b_sel = ya[i*CHUNK +: CHUNK];
            end
        end
    end

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a  (a_sel),
        .b  (b_sel),
        .ci (c),
        .s  (sum),
        .co (co)
    );

    // Result word with the current chunk merged in; also used to derive
    // the overflow flag from the final sum on the last RUN edge.
    always_comb begin
        s_upd = S;
        for (int i = 0; i < NCHUNK; i++) begin
            if (k == KW'(i)) begin
                s_upd[i*CHUNK +: CHUNK] = sum;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_RUN;
            ST_RUN:  if (last)  state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs. Subtraction is X + ~Y + ~borrow,
    // so the inversion happens once at capture time.
    always_ff @(posedge clk) begin
        if (rst) begin
            xa   <= '0;
            ya   <= '0;
            c    <= 1'b0;
            k    <= '0;
            S    <= '0;
            Cout <= 1'b0;
            V    <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        xa   <= X;
                        ya   <= sub ? ~Y : Y;
                        c    <= sub ? ~Cin : Cin;
                        k    <= '0;
                        S    <= '0;
                        Cout <= 1'b0;
                        V    <= 1'b0;
                        busy <= 1'b1;
                    end
                end
                ST_RUN: begin
                    S <= s_upd;
                    c <= co;
                    k <= k + KW'(1);
                    if (last) begin
                        Cout <= co;
                        V    <= (xa[WIDTH-1] == ya[WIDTH-1]) &&
                                (s_upd[WIDTH-1] != xa[WIDTH-1]);
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: three instances (CHUNK=2, 1, 8) with
// shared operands and a private start per instance.
module tb_seq_chunk_adder;

    logic       clk;
    logic       rst;
    logic       sub;
    logic [7:0] X;
    logic [7:0] Y;
    logic       Cin;
    logic       start_w [3];
    logic       busy_w  [3];
    logic       done_w  [3];
    logic [7:0] s_w     [3];
    logic       cout_w  [3];
    logic       v_w     [3];

    int checks   = 0;
    int failures = 0;

    seq_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut_c2 (
        .clk(clk), .rst(rst), .start(start_w[0]), .sub(sub), .X(X), .Y(Y),
        .Cin(Cin), .busy(busy_w[0]), .done(done_w[0]), .S(s_w[0]),
        .Cout(cout_w[0]), .V(v_w[0])
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) dut_c1 (
        .clk(clk), .rst(rst), .start(start_w[1]), .sub(sub), .X(X), .Y(Y),
        .Cin(Cin), .busy(busy_w[1]), .done(done_w[1]), .S(s_w[1]),
        .Cout(cout_w[1]), .V(v_w[1])
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut_c8 (
        .clk(clk), .rst(rst), .start(start_w[2]), .sub(sub), .X(X), .Y(Y),
        .Cin(Cin), .busy(busy_w[2]), .done(done_w[2]), .S(s_w[2]),
        .Cout(cout_w[2]), .V(v_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation on instance d; checks busy length, done pulse and result.
    task automatic run_op(input int d, input logic [7:0] x, input logic [7:0] y,
                          input logic sb, input logic ci, input logic [7:0] es,
                          input logic ec, input logic ev, input int enc, input string tag);
        int cnt;
        X   = x;
        Y   = y;
        sub = sb;
        Cin = ci;
        start_w[d] = 1'b1;
        step();
        start_w[d] = 1'b0;
        cnt = 0;
        while (busy_w[d] && cnt < 50) begin
            cnt++;
            step();
        end
        chk({tag, "_busycyc"}, cnt, enc);
        chk({tag, "_done"}, done_w[d], 1'b1);
        chk({tag, "_S"}, s_w[d], es);
        chk({tag, "_Cout"}, cout_w[d], ec);
        chk({tag, "_V"}, v_w[d], ev);
        step();
        chk({tag, "_done_end"}, done_w[d], 1'b0);
        chk({tag, "_S_hold"}, s_w[d], es);
    endtask

    logic [7:0] vx  [6] = '{8'h0F, 8'hFF, 8'h7F, 8'h80, 8'h05, 8'h05};
    logic [7:0] vy  [6] = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h07, 8'h07};
    logic       vsb [6] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
    logic       vci [6] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
    logic [7:0] vs  [6] = '{8'h10, 8'h00, 8'h80, 8'h7F, 8'hFE, 8'hFD};
    logic       vc  [6] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0};
    logic       vv  [6] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
    int         nc  [3] = '{4, 8, 1};
    logic [7:0] hold_exp [4] = '{8'd3, 8'd27, 8'd51, 8'd75};

    initial begin
        int nd;
        rst = 1'b1;
        sub = 1'b0;
        Cin = 1'b0;
        X   = 8'h00;
        Y   = 8'h00;
        for (int d = 0; d < 3; d++) start_w[d] = 1'b0;
        step();
        step();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_busy%0d", d), busy_w[d], 1'b0);
            chk($sformatf("rst_done%0d", d), done_w[d], 1'b0);
            chk($sformatf("rst_S%0d", d), s_w[d], 8'h00);
            chk($sformatf("rst_Cout%0d", d), cout_w[d], 1'b0);
            chk($sformatf("rst_V%0d", d), v_w[d], 1'b0);
        end
        rst = 1'b0;
        step();

        // Directed vectors on all three chunk widths.
        for (int d = 0; d < 3; d++) begin
            for (int v = 0; v < 6; v++) begin
                run_op(d, vx[v], vy[v], vsb[v], vci[v], vs[v], vc[v], vv[v], nc[d],
                       $sformatf("vec%0d_d%0d", v, d));
            end
        end

        // start held high with operands changing every cycle (CHUNK=2).
        nd = 0;
        start_w[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            X   = 8'(i * 3 + 1);
            Y   = 8'(i + 2);
            sub = 1'b0;
            Cin = 1'b0;
            step();
            if (done_w[0]) begin
                chk("hold_phase", i % 6, 4);
                if (nd < 4) chk($sformatf("hold_S%0d", nd), s_w[0], hold_exp[nd]);
                nd++;
            end
        end
        chk("hold_dones", nd, 3);
        start_w[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            X = 8'hAA;
            Y = 8'h55;
            step();
            if (done_w[0]) begin
                if (nd < 4) chk("hold_S_last", s_w[0], hold_exp[nd]);
                nd++;
            end
        end
        chk("hold_dones_total", nd, 4);

        // Reset in the middle of RUN discards the operation.
        X   = 8'h05;
        Y   = 8'h0A;
        sub = 1'b0;
        Cin = 1'b0;
        start_w[0] = 1'b1;
        step();
        start_w[0] = 1'b0;
        chk("mid_busy", busy_w[0], 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_busy", busy_w[0], 1'b0);
        chk("mid_rst_done", done_w[0], 1'b0);
        chk("mid_rst_S", s_w[0], 8'h00);
        chk("mid_rst_Cout", cout_w[0], 1'b0);
        chk("mid_rst_V", v_w[0], 1'b0);
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done_w[0] || busy_w[0]) nd++;
        end
        chk("mid_rst_idle", nd, 0);
        run_op(0, 8'h3C, 8'h0A, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 4, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
